// File: rtl/usart_rx_fifo_ctrl.sv
// rtl/usart_rx_fifo_ctrl.sv - USART0 receive FIFO, status flags and receive-complete interrupt
module usart_rx_fifo_ctrl #(
    parameter int         DEPTH    = 2,
    parameter logic [7:0] UDR_ADDR = 8'hC6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rxen,
    input  logic                     rxcie,
    input  logic                     frame_done,
    input  logic [8:0]               frame_data,
    input  logic                     frame_fe,
    input  logic                     frame_pe,
    input  logic [7:0]               addr,
    input  logic                     read,
    output logic [7:0]               rd_data,
    output logic                     rxb8,
    output logic                     rxc,
    output logic                     fe,
    output logic                     upe,
    output logic                     dor,
    output logic                     rx_irq,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    // Entry layout: [11] dor, [10] pe, [9] fe, [8:0] frame bits
    logic [11:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          dor_pending;

    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          overflow;
    logic [11:0]   head;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop      = rxen && read && (addr == UDR_ADDR) && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    assign push     = rxen && frame_done && (!full || pop);
    assign overflow = rxen && frame_done && full && !pop;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {dor_pending, frame_pe, frame_fe, frame_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            dor_pending <= 1'b0;
        end else if (!rxen) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            dor_pending <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // The overrun is handed to the next stored frame, then forgotten here.
            if (push) begin
                dor_pending <= 1'b0;
            end else if (overflow) begin
                dor_pending <= 1'b1;
            end
        end
    end

    assign rxc     = !empty;
    assign rd_data = (rxc && rxen) ? head[7:0] : 8'h00;
    assign rxb8    = rxc & head[8];
    assign fe      = rxc & head[9];
    assign upe     = rxc & head[10];
    assign dor     = dor_pending | (rxc & head[11]);
    assign rx_irq  = rxc & rxcie;

endmodule

// File: tb/tb_usart_rx_fifo_ctrl.sv
// tb/tb_usart_rx_fifo_ctrl.sv - self-checking bench for usart_rx_fifo_ctrl with a queue-based model
module tb_usart_rx_fifo_ctrl;

    localparam int         DEPTH = 2;
    localparam logic [7:0] UDR   = 8'hC6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxen;
    logic       rxcie;
    logic       frame_done;
    logic [8:0] frame_data;
    logic       frame_fe;
    logic       frame_pe;
    logic [7:0] addr;
    logic       read;
    logic [7:0] rd_data;
    logic       rxb8, rxc, fe, upe, dor, rx_irq;
    logic [1:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a queue of stored frames {dor, pe, fe, data[8:0]} plus the sticky overrun bit.
    logic [11:0] q [$];
    logic        m_dorp;

    usart_rx_fifo_ctrl #(.DEPTH(DEPTH), .UDR_ADDR(UDR)) dut (
        .clk(clk), .rst_n(rst_n), .rxen(rxen), .rxcie(rxcie),
        .frame_done(frame_done), .frame_data(frame_data), .frame_fe(frame_fe), .frame_pe(frame_pe),
        .addr(addr), .read(read), .rd_data(rd_data), .rxb8(rxb8), .rxc(rxc), .fe(fe),
        .upe(upe), .dor(dor), .rx_irq(rx_irq), .count(count)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic fd, input logic [8:0] d, input logic f, input logic p,
                       input logic rd, input logic [7:0] a, input logic rx);
        logic        mpop;
        logic        room;
        logic [11:0] tmp;
        frame_done = fd; frame_data = d; frame_fe = f; frame_pe = p;
        read = rd; addr = a; rxen = rx;
        if (!rx) begin
            q.delete();
            m_dorp = 1'b0;
        end else begin
            mpop = rd && (a == UDR) && (q.size() != 0);
            room = (q.size() < DEPTH) || mpop;
            if (mpop) tmp = q.pop_front();
            if (fd) begin
                if (room) begin
                    q.push_back({m_dorp, p, f, d});
                    m_dorp = 1'b0;
                end else begin
                    m_dorp = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        frame_done = 1'b0; frame_data = '0; frame_fe = 1'b0; frame_pe = 1'b0;
        read = 1'b0; addr = 8'h00; rxen = 1'b1;
        #1;
    endtask

    task automatic push_byte(input logic [8:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic pop_udr();
        cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, UDR, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rxen = 1'b1; rxcie = 1'b1; frame_done = 1'b0; frame_data = '0;
        frame_fe = 1'b0; frame_pe = 1'b0; addr = 8'h00; read = 1'b0;
        q.delete(); m_dorp = 1'b0;
        #2;
        n_checks++; if ({rd_data, rxb8, rxc, fe, upe, dor, rx_irq, count} !== 16'h0) $display("FAIL reset_outputs got %h want 0", {rd_data, rxb8, rxc, fe, upe, dor, rx_irq, count}); else n_pass++;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        push_byte(9'h0A5);
        n_checks++; if (rxc !== 1'b1) $display("FAIL single_rxc got %b want 1", rxc); else n_pass++;
        n_checks++; if (rd_data !== 8'hA5) $display("FAIL single_data got %h want a5", rd_data); else n_pass++;
        n_checks++; if (rx_irq !== 1'b1) $display("FAIL single_irq got %b want 1", rx_irq); else n_pass++;
        n_checks++; if (count !== 2'd1) $display("FAIL single_count got %0d want 1", count); else n_pass++;
        pop_udr();
        n_checks++; if ({rxc, rd_data} !== 9'h000) $display("FAIL single_after_pop got rxc=%b data=%h want 0", rxc, rd_data); else n_pass++;
    endtask

    task automatic test_nine_bit();
        cyc(1'b1, 9'h13C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        n_checks++; if ({rxb8, fe, upe} !== 3'b111) $display("FAIL nine_flags got %b want 111", {rxb8, fe, upe}); else n_pass++;
        n_checks++; if (rd_data !== 8'h3C) $display("FAIL nine_data got %h want 3c", rd_data); else n_pass++;
        pop_udr();
        n_checks++; if ({rxb8, fe, upe} !== 3'b000) $display("FAIL nine_flags_clear got %b want 000", {rxb8, fe, upe}); else n_pass++;
    endtask

    task automatic test_overflow();
        push_byte(9'h011); push_byte(9'h022); push_byte(9'h033);
        n_checks++; if (count !== 2'd2) $display("FAIL ovf_count got %0d want 2", count); else n_pass++;
        n_checks++; if (dor !== 1'b1) $display("FAIL ovf_dor got %b want 1", dor); else n_pass++;
        n_checks++; if (rd_data !== 8'h11) $display("FAIL ovf_first got %h want 11", rd_data); else n_pass++;
        pop_udr();
        n_checks++; if (rd_data !== 8'h22) $display("FAIL ovf_second got %h want 22", rd_data); else n_pass++;
        pop_udr();
        n_checks++; if ({count, dor} !== 3'b001) $display("FAIL ovf_drained got count=%0d dor=%b want 0/1", count, dor); else n_pass++;
        push_byte(9'h044);
        n_checks++; if ({rd_data, dor} !== 9'h089) $display("FAIL ovf_carry got data=%h dor=%b want 44/1", rd_data, dor); else n_pass++;
        pop_udr();
        n_checks++; if (dor !== 1'b0) $display("FAIL ovf_dor_clear got %b want 0", dor); else n_pass++;
    endtask

    task automatic test_simul_full();
        push_byte(9'h011); push_byte(9'h022);
        cyc(1'b1, 9'h055, 1'b0, 1'b0, 1'b1, UDR, 1'b1);
        n_checks++; if (count !== 2'd2) $display("FAIL simul_count got %0d want 2", count); else n_pass++;
        n_checks++; if (dor !== 1'b0) $display("FAIL simul_dor got %b want 0", dor); else n_pass++;
        n_checks++; if (rd_data !== 8'h22) $display("FAIL simul_head1 got %h want 22", rd_data); else n_pass++;
        pop_udr();
        n_checks++; if (rd_data !== 8'h55) $display("FAIL simul_head2 got %h want 55", rd_data); else n_pass++;
        pop_udr();
    endtask

    task automatic test_empty_wrong_addr();
        pop_udr();
        n_checks++; if ({rd_data, count, dor} !== 11'h0) $display("FAIL empty_read got data=%h count=%0d dor=%b want 0", rd_data, count, dor); else n_pass++;
        push_byte(9'h077);
        cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 8'hC0, 1'b1);
        n_checks++; if ({count, rd_data} !== {2'd1, 8'h77}) $display("FAIL wrong_addr got count=%0d data=%h want 1/77", count, rd_data); else n_pass++;
        pop_udr();
    endtask

    task automatic test_flush();
        push_byte(9'h011); push_byte(9'h022); push_byte(9'h033);
        n_checks++; if ({count, dor} !== 3'b101) $display("FAIL flush_pre got count=%0d dor=%b want 2/1", count, dor); else n_pass++;
        cyc(1'b1, 9'h066, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++; if ({count, rxc, dor} !== 4'b0000) $display("FAIL flush_post got count=%0d rxc=%b dor=%b want 0", count, rxc, dor); else n_pass++;
        push_byte(9'h099);
        n_checks++; if ({count, rd_data} !== {2'd1, 8'h99}) $display("FAIL flush_resume got count=%0d data=%h want 1/99", count, rd_data); else n_pass++;
        pop_udr();
    endtask

    task automatic test_random();
        logic [7:0] exp_data;
        logic       exp_rxc, exp_dor;
        logic [2:0] exp_flags;
        int         bad;
        for (int i = 0; i < 400; i++) begin
            rxcie = 1'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 1)), 9'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? 8'hC0 : UDR,
                ($urandom_range(0, 24) != 0));
            exp_rxc   = (q.size() != 0);
            exp_data  = exp_rxc ? q[0][7:0] : 8'h00;
            exp_flags = exp_rxc ? {q[0][8], q[0][9], q[0][10]} : 3'b000;
            exp_dor   = m_dorp | (exp_rxc & q[0][11]);
            bad = 0;
            if (count !== 2'(q.size())) bad++;
            if (rxc !== exp_rxc) bad++;
            if (rd_data !== exp_data) bad++;
            if ({rxb8, fe, upe} !== exp_flags) bad++;
            if (dor !== exp_dor) bad++;
            if (rx_irq !== (exp_rxc & rxcie)) bad++;
            n_checks++;
            if (bad != 0) $display("FAIL random_cycle%0d got count=%0d rxc=%b data=%h flags=%b dor=%b irq=%b want count=%0d rxc=%b data=%h flags=%b dor=%b irq=%b",
                                   i, count, rxc, rd_data, {rxb8, fe, upe}, dor, rx_irq,
                                   q.size(), exp_rxc, exp_data, exp_flags, exp_dor, exp_rxc & rxcie);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        rxcie = 1'b1;
        push_byte(9'h1AB); push_byte(9'h0CD);
        n_checks++; if (count !== 2'd2) $display("FAIL areset_pre got count=%0d want 2", count); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({rd_data, rxb8, rxc, fe, upe, dor, rx_irq, count} !== 16'h0) $display("FAIL areset_outputs got %h want 0", {rd_data, rxb8, rxc, fe, upe, dor, rx_irq, count}); else n_pass++;
        q.delete(); m_dorp = 1'b0;
        #2 rst_n = 1'b1;
        push_byte(9'h05A);
        n_checks++; if ({count, rd_data} !== {2'd1, 8'h5A}) $display("FAIL areset_resume got count=%0d data=%h want 1/5a", count, rd_data); else n_pass++;
        pop_udr();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_nine_bit();
        test_overflow();
        test_simul_full();
        test_empty_wrong_addr();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usart_rx_fifo_ctrl.md
# usart_rx_fifo_ctrl

Receive-side buffer controller for USART0. It sits between the frame receiver and the CPU register interface. It captures each completed frame (data, 9th bit, frame/parity error) into a small FIFO and sequences CPU pops on reads of UDR. It also generates the RXC, FE, UPE and DOR status flags and the receive-complete interrupt request.

## Interface
- DEPTH, 2, FIFO entries (power of two, 2..8)
- UDR_ADDR, 8'hC6, address whose read pops the FIFO
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rxen  in  1  receiver enable; low flushes the buffer
- rxcie  in  1  receive-complete interrupt enable
- frame_done  in  1  one-cycle strobe from the receiver, frame complete
- frame_data  in  9  received bits, [8] = 9th bit (0 for 5–8 bit frames)
- frame_fe  in  1  frame error of the strobed frame
- frame_pe  in  1  parity error of the strobed frame
- addr  in  8  CPU register address
- read  in  1  CPU read strobe, one cycle per access
- rd_data  out  8  head data [7:0]; 0 when empty
- rxb8  out  1  head 9th bit
- rxc  out  1  FIFO not empty
- fe  out  1  head frame error
- upe  out  1  head parity error
- dor  out  1  data overrun flag
- rx_irq  out  1  rxc & rxcie
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Entry is 12 bits: data[8:0], fe, pe, dor. Circular buffer with wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH.
- Push: frame_done & rxen & (count<DEPTH, or a pop occurs in the same cycle). The stored dor bit equals dor_pending, and dor_pending is cleared on that push.
- Overflow: frame_done & rxen & count==DEPTH & no pop in the same cycle. The frame is discarded and dor_pending is set (sticky). FIFO contents are unchanged.
- Pop: read & addr==UDR_ADDR & count!=0. rd_data presents the head combinationally in the same cycle, and rd_ptr advances at the clock edge.
- A read with count==0 returns rd_data=0, with no pointer or count change and no error.
- Push and pop in the same cycle:
  - Count is unchanged. Both pointers advance.
  - If count==0, the pop is ignored and the push is accepted (count becomes 1).
  - If count==DEPTH, both are accepted and no overflow is recorded.
- Status outputs are combinational from the head entry and are 0 when empty:
  - rxb8, fe, upe.
  - dor = dor_pending | (rxc & head.dor).
- rxen low, sampled at a clock edge:
  - count, wr_ptr, rd_ptr and dor_pending are cleared.
  - frame_done is ignored while rxen is low.
  - Reads return 0.
  - Entry storage need not be cleared.
- Reset (rst_n low, asynchronous): count=0, pointers=0, dor_pending=0. This puts every output at 0: rd_data, rxb8, rxc, fe, upe, dor, rx_irq, count.

## Timing
- frame_done sampled at edge N: rxc, rd_data and the status bits are valid after edge N (next cycle). rx_irq follows in the same cycle.
- Pop at edge N: the next entry, or the empty state, is visible after edge N.
- Overflow at edge N: dor=1 after edge N and stays high until the next accepted push clears dor_pending. After that, dor stays high while the entry carrying the flag is at the head.
- There are no wait states: the CPU may read every cycle and the receiver may strobe every cycle.
- rst_n assertion mid-transfer discards all entries immediately, with no clock required. Deassertion is synchronised upstream.

## Test plan
- Single frame:
  - Stimulus: frame_done with frame_data=9'h0A5, fe=0, pe=0.
  - Response: next cycle rxc=1, rd_data=8'hA5, rx_irq=rxcie, count=1. After a read at 8'hC6: rxc=0, rd_data=0.
- 9-bit frame and error propagation:
  - Stimulus: push 9'h13C with fe=1, pe=1.
  - Response: rxb8=1, rd_data=8'h3C, fe=1, upe=1. All three clear after the pop.
- Overflow (DEPTH=2):
  - Stimulus: push 8'h11, then 8'h22, then 8'h33 with no reads.
  - Response: count=2, dor=1, reads return 8'h11 then 8'h22, and 8'h33 is lost.
  - Follow-on: push 8'h44. Its entry has dor=1, and dor falls only after 8'h44 is popped.
- Simultaneous pop and push at full:
  - Stimulus: FIFO holds 8'h11, 8'h22; read at 8'hC6 in the same cycle as frame_done 8'h55.
  - Response: count stays 2, dor=0, next reads return 8'h22 then 8'h55.
- Empty-read and wrong-address reads:
  - Stimulus: read at 8'hC6 with count=0; read at 8'hC0 with count=1.
  - Response: the first returns 0 with no state change; the second does not pop (count stays 1).
- rxen flush and reset:
  - Stimulus: with 2 entries and dor=1, drop rxen for one cycle.
  - Response: count=0, rxc=0, dor=0, and a frame_done in that cycle is ignored.
  - Follow-on: assert rst_n low mid-stream. All outputs go to 0 asynchronously.
